// File: rtl/processor_pkg.sv
// Shared constants for the accumulator processor: data width, instruction
// field positions and opcode encodings.
package processor_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;

  localparam int OPC_HI = 10;
  localparam int OPC_LO = 8;
  localparam int REG_HI = 7;
  localparam int REG_LO = 5;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;
endpackage

// File: rtl/processor_alu.sv
// Combinational ALU: computes the new accumulator value, its sign and the
// two's-complement overflow of ADD/SUB.
module processor_alu
  import processor_pkg::*;
(
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result,
  output logic              sign,
  output logic              overflow
);
  always_comb begin
    result   = acc;
    overflow = 1'b0;
    case (opcode)
      OP_LDI: result = operand;
      OP_ADD: begin
        result   = acc + operand;
        overflow = (acc[DATA_W-1] == operand[DATA_W-1]) &&
                   (result[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_MOV: result = acc;  // value copied into the register file
      OP_SUB: begin
        result   = acc - operand;
        overflow = (acc[DATA_W-1] != operand[DATA_W-1]) &&
                   (result[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_AND: result = acc & operand;
      OP_OR:  result = acc | operand;
      OP_XOR: result = acc ^ operand;
      OP_NOT: result = ~acc;
      default: result = acc;
    endcase
  end

  assign sign = result[DATA_W-1];
endmodule

// File: rtl/processor.sv
// Accumulator processor top: execute-request edge detector, register file,
// accumulator and registered observation outputs.
module processor
  import processor_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         instruction,
  input  logic                execute_next,
  output logic [DATA_W-1:0]   output_result,
  output logic                signflag,
  output logic                overflowflag,
  output logic [DATA_W-1:0]   accummulator,
  output logic [DATA_W-1:0]   R1,
  output logic [2:0]          regsiter_operand,
  output logic [2:0]          opcode
);
  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] result_reg;
  logic              sign_reg;
  logic              overflow_reg;
  logic [2:0]        opcode_reg;
  logic [2:0]        rop_reg;
  logic              exec_prev_reg;

  logic [2:0]        inst_op;
  logic [2:0]        inst_reg;
  logic [DATA_W-1:0] inst_imm;
  logic [DATA_W-1:0] alu_operand;
  logic [DATA_W-1:0] alu_result;
  logic              alu_sign;
  logic              alu_overflow;
  logic              fire;

  assign inst_op  = instruction[OPC_HI:OPC_LO];
  assign inst_reg = instruction[REG_HI:REG_LO];
  assign inst_imm = instruction[IMM_HI:IMM_LO];
  assign fire     = execute_next && !exec_prev_reg;

  // LDI takes the immediate; every other op reads the pre-edge register value.
  assign alu_operand = (inst_op == OP_LDI) ? inst_imm : regs_reg[inst_reg];

  processor_alu u_alu (
    .opcode   (inst_op),
    .acc      (acc_reg),
    .operand  (alu_operand),
    .result   (alu_result),
    .sign     (alu_sign),
    .overflow (alu_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      sign_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      opcode_reg    <= '0;
      rop_reg       <= '0;
      exec_prev_reg <= 1'b0;
    end else begin
      exec_prev_reg <= execute_next;
      if (fire) begin
        opcode_reg <= inst_op;
        rop_reg    <= inst_reg;
        result_reg <= alu_result;
        if (inst_op == OP_MOV) begin
          regs_reg[inst_reg] <= acc_reg;
        end else begin
          acc_reg      <= alu_result;
          sign_reg     <= alu_sign;
          overflow_reg <= alu_overflow;
        end
      end
    end
  end

  assign output_result    = result_reg;
  assign signflag         = sign_reg;
  assign overflowflag     = overflow_reg;
  assign accummulator     = acc_reg;
  assign R1               = regs_reg[1];
  assign regsiter_operand = rop_reg;
  assign opcode           = opcode_reg;
endmodule

// File: tb/tb_processor.sv
// Scoreboard bench for the accumulator processor: stimulus pushes expected
// observations tagged with a cycle stamp, a monitor pops and compares them.
module tb_processor;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] instruction;
  logic        execute_next;
  logic [7:0]  output_result;
  logic        signflag;
  logic        overflowflag;
  logic [7:0]  accummulator;
  logic [7:0]  R1;
  logic [2:0]  regsiter_operand;
  logic [2:0]  opcode;

  processor dut (
    .clk              (clk),
    .reset            (reset),
    .instruction      (instruction),
    .execute_next     (execute_next),
    .output_result    (output_result),
    .signflag         (signflag),
    .overflowflag     (overflowflag),
    .accummulator     (accummulator),
    .R1               (R1),
    .regsiter_operand (regsiter_operand),
    .opcode           (opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       stamp;
    string    tag;
    int       acc;
    int       r1;
    int       res;
    int       sgn;
    int       ovf;
    int       opc;
    int       rop;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state (plain integers).
  int m_acc;
  int m_regs[8];
  int m_res, m_sgn, m_ovf, m_opc, m_rop;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_acc = 0;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_res = 0; m_sgn = 0; m_ovf = 0; m_opc = 0; m_rop = 0;
  endfunction

  function automatic void model_exec(input logic [10:0] ins);
    int op, r, imm, b, s;
    op  = int'(ins[10:8]);
    r   = int'(ins[7:5]);
    imm = int'(ins[7:0]);
    b   = m_regs[r];
    m_opc = op;
    m_rop = r;
    if (op == 2) begin
      m_regs[r] = m_acc;
      m_res = m_acc;
      return;
    end
    m_ovf = 0;
    case (op)
      0: m_acc = imm;
      1: begin
        s = (m_acc > 127 ? m_acc - 256 : m_acc) + (b > 127 ? b - 256 : b);
        m_ovf = (s > 127 || s < -128) ? 1 : 0;
        m_acc = (m_acc + b) % 256;
      end
      3: begin
        s = (m_acc > 127 ? m_acc - 256 : m_acc) - (b > 127 ? b - 256 : b);
        m_ovf = (s > 127 || s < -128) ? 1 : 0;
        m_acc = (m_acc - b + 256) % 256;
      end
      4: m_acc = m_acc & b;
      5: m_acc = m_acc | b;
      6: m_acc = m_acc ^ b;
      default: m_acc = 255 - m_acc;
    endcase
    m_res = m_acc;
    m_sgn = (m_acc >= 128) ? 1 : 0;
  endfunction

  function automatic void push_exp(input int stamp, input string tag);
    exp_t e;
    e.stamp = stamp; e.tag = tag;
    e.acc = m_acc; e.r1 = m_regs[1]; e.res = m_res; e.sgn = m_sgn;
    e.ovf = m_ovf; e.opc = m_opc; e.rop = m_rop;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares each queued expectation on the negedge after its edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.stamp < cyc) chk({e.tag, " stale"}, e.stamp, cyc);
        chk({e.tag, " acc"},    int'(accummulator),     e.acc);
        chk({e.tag, " r1"},     int'(R1),               e.r1);
        chk({e.tag, " result"}, int'(output_result),    e.res);
        chk({e.tag, " sign"},   int'(signflag),         e.sgn);
        chk({e.tag, " ovf"},    int'(overflowflag),     e.ovf);
        chk({e.tag, " opcode"}, int'(opcode),           e.opc);
        chk({e.tag, " regop"},  int'(regsiter_operand), e.rop);
        $display("txn %-10s cyc=%0d acc=%02h r1=%02h res=%02h s=%0d v=%0d op=%0d r=%0d",
                 e.tag, cyc, accummulator, R1, output_result, signflag,
                 overflowflag, opcode, regsiter_operand);
      end
    end
  end

  // Issue one instruction; execute_next stays high for 'hold' edges, and the
  // state is expected to stay put for every extra edge it is held.
  task automatic issue(input logic [10:0] ins, input string tag, input int hold = 1);
    @(negedge clk);
    instruction  = ins;
    execute_next = 1'b1;
    model_exec(ins);
    for (int k = 1; k <= hold; k++) push_exp(cyc + k, tag);
    repeat (hold) @(negedge clk);
    execute_next = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset        = 1'b1;
    execute_next = 1'b1;
    instruction  = 11'h055;
    model_reset();
    push_exp(cyc + 1, tag);
    push_exp(cyc + 2, tag);
    repeat (2) @(negedge clk);
    reset        = 1'b0;
    execute_next = 1'b0;
  endtask

  initial begin
    logic [10:0] ins;
    reset        = 1'b1;
    execute_next = 1'b0;
    instruction  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("reset");

    issue(11'h004, "LDI4");
    issue(11'h23F, "MOVR1");
    issue(11'h006, "LDI6");
    issue(11'h25F, "MOVR2");
    issue(11'h13F, "ADDR1");
    issue(11'h65F, "XORR2");
    issue(11'h7FF, "NOT");
    chk("seq acc model", m_acc, 8'hF3);

    issue(11'h13F, "ADDhold", 5);

    issue(11'h001, "LDI1");
    issue(11'h220, "MOVR1b");
    issue(11'h07F, "LDI7F");
    issue(11'h120, "ADDovf");
    issue(11'h080, "LDI80");
    issue(11'h320, "SUBovf");
    issue(11'h000, "LDI0");

    for (int n = 0; n < 150; n++) begin
      ins = 11'($urandom_range(0, 2047));
      issue(ins, "rand");
    end

    issue(11'h05A, "LDI5A");
    issue(11'h220, "MOVR1c");
    issue(11'h120, "ADDpre");
    do_reset("midreset");
    issue(11'h7FF, "NOTpost");

    repeat (4) @(negedge clk);
    chk("queue drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
